fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter and drives the byte address into the combinational instruction memory. Latches the returned word into the IF/ID pipeline register. Handles sequential fetch, stalls, branch and jump redirection, and squashing of wrong-path instructions.

---
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Redirects on taken branches and jumps, and squashes the wrong-path word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    output logic [IMEM_AW-1:0] imem_add,
    input  logic [31:0]        imem_instruc,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic [31:0]        fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc4;
    logic [31:0] w_jump_target;
    logic        w_jump_ok;

    assign w_pc4         = r_pc + 32'd4;
    assign w_jump_target = {r_if_id_pc4[31:28], r_if_id_instr[25:0], 2'b00};
    assign w_jump_ok     = jump & r_if_id_valid;

    // Memory sees only the low PC bits, so fetch aliases every 2^IMEM_AW bytes.
    assign imem_add = r_pc[IMEM_AW-1:0];

    // Priority: reset, branch (older instruction), jump, stall, sequential fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (branch_taken) begin
            r_pc          <= branch_target;
            r_if_id_instr <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (w_jump_ok) begin
            r_pc          <= w_jump_target;
            r_if_id_instr <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= w_pc4;
            r_if_id_instr <= imem_instruc;
            r_if_id_pc4   <= w_pc4;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign pc          = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level model checked every cycle plus literal spot checks.
module tb_fetch_stage;

    localparam int unsigned IMEM_AW    = 7;
    localparam int unsigned IMEM_BYTES = 128;
    localparam int unsigned IMEM_WORDS = IMEM_BYTES / 4;

    logic               clk;
    logic               rst_n;
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [IMEM_AW-1:0] imem_add;
    logic [31:0]        imem_instruc;
    logic [31:0]        pc;
    logic [31:0]        if_id_instr;
    logic [31:0]        if_id_pc4;
    logic               if_id_valid;
    logic [31:0]        fetch_count;

    logic [31:0] mem [IMEM_WORDS];

    int n_vec;
    int n_err;

    // Model state, kept in plain spec terms.
    logic        m_known;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_count;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .imem_add     (imem_add),
        .imem_instruc (imem_instruc),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
    );

    assign imem_instruc = mem[imem_add >> 2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model advances on each rising edge from the inputs set up on the prior falling edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1'b1;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_count = 32'h0;
        end else if (m_known) begin
            if (branch_taken) begin
                m_pc = branch_target;
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (jump && m_valid) begin
                m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = mem[(m_pc % IMEM_BYTES) / 4];
                m_pc    = m_pc + 32'd4;
                m_pc4   = m_pc;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model once reset has been seen.
    always @(negedge clk) begin
        if (m_known) begin
            chk("model_pc",       pc,                 m_pc);
            chk("model_imem_add", 32'(imem_add),      m_pc % IMEM_BYTES);
            chk("model_instr",    if_id_instr,        m_instr);
            chk("model_pc4",      if_id_pc4,          m_pc4);
            chk("model_valid",    32'(if_id_valid),   32'(m_valid));
            chk("model_count",    fetch_count,        m_count);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_known = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h8C09_0004;
        mem[3] = 32'hAC08_0008;
        mem[4] = 32'h0800_0003;
        mem[6] = 32'h8C09_0008;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0;
        cyc(); cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        rst_n = 1'b1;
        cyc();
        chk("f1_instr", if_id_instr, 32'h2008_0001);
        chk("f1_pc4", if_id_pc4, 32'h4);
        chk("f1_pc", pc, 32'h4);
        chk("f1_valid", 32'(if_id_valid), 32'h1);
        cyc();
        chk("f2_instr", if_id_instr, 32'h8C09_0004);
        chk("f2_pc", pc, 32'h8);
        chk("f2_count", fetch_count, 32'h2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", if_id_instr, 32'h8C09_0004);
            chk("stall_count", fetch_count, 32'h2);
        end
        stall = 1'b0;
        cyc();
        chk("resume_pc", pc, 32'hC);
        cyc(); cyc();
        chk("pre_jump_instr", if_id_instr, 32'h0800_0003);
        chk("pre_jump_pc", pc, 32'h14);

        jump = 1'b1;
        cyc();
        jump = 1'b0;
        chk("jump_pc", pc, 32'hC);
        chk("jump_valid", 32'(if_id_valid), 32'h0);
        chk("jump_count", fetch_count, 32'h5);
        cyc();
        chk("post_jump_instr", if_id_instr, 32'hAC08_0008);
        chk("post_jump_pc4", if_id_pc4, 32'h10);
        cyc();

        // Branch beats a simultaneous stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h18;
        cyc();
        chk("br_stall_pc", pc, 32'h18);
        chk("br_stall_valid", 32'(if_id_valid), 32'h0);
        // Jump with an empty IF/ID is ignored.
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b1;
        cyc();
        jump = 1'b0;
        chk("br_next_instr", if_id_instr, 32'h8C09_0008);
        chk("jump_ignored_pc", pc, 32'h1C);

        branch_taken = 1'b1; branch_target = 32'h20; jump = 1'b1;
        cyc();
        jump = 1'b0;
        chk("br_vs_jump_pc", pc, 32'h20);

        branch_target = 32'h22;
        cyc();
        branch_taken = 1'b0;
        chk("misalign_pc", pc, 32'h22);
        cyc();
        chk("misalign_instr", if_id_instr, 32'h1000_0008);
        chk("misalign_pc4", if_id_pc4, 32'h26);

        branch_taken = 1'b1; branch_target = 32'h78;
        cyc();
        branch_taken = 1'b0;
        cyc(); cyc();
        chk("wrap_pc", pc, 32'h80);
        chk("wrap_add", 32'(imem_add), 32'h0);
        cyc();
        chk("wrap_instr", if_id_instr, 32'h2008_0001);
        chk("wrap_pc4", if_id_pc4, 32'h84);

        stall = 1'b1;
        cyc();
        rst_n = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        cyc();
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_instr", if_id_instr, 32'h0);
        chk("rst_mid_pc4", if_id_pc4, 32'h0);
        chk("rst_mid_valid", 32'(if_id_valid), 32'h0);
        chk("rst_mid_count", fetch_count, 32'h0);
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        cyc();
        chk("rerun_instr", if_id_instr, 32'h2008_0001);
        chk("rerun_count", fetch_count, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
